mux_share_arbiter: RTL

Round-robin controller that shares one 2:1 mux output channel between two requesters. It owns the mux select `s`, decides which requester drives `y`, counts accepted beats, and forces a hand-over after a bounded burst so that neither requester can starve the other. It sits directly in front of the shared 2:1 mux datapath and presents a valid/ready channel to the downstream consumer.

---
 rtl/mux_share_arbiter_if.sv | 48 ++++
 rtl/mux_share_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter_if.sv
// rtl/mux_share_arbiter_if.sv - requester/consumer channel of the shared 2:1 mux arbiter
//
// Signals:
//   req[1:0]    per-requester request, req[k] means in_k holds data
//   in0, in1    requester data, WIDTH bits each
//   gnt[1:0]    one-hot registered grant, 00 when idle
//   s           registered mux select, 0 picks in0, 1 picks in1
//   y           shared output, combinational mux of in0/in1 by s
//   y_valid     gnt[s] & req[s], combinational
//   y_ready     consumer accepts a beat when y_valid & y_ready at a rising edge
//
// Modports:
//   slave   the arbiter side
//   master  the requesters plus downstream consumer side
interface mux_share_arbiter_if #(
    parameter int WIDTH = 1
) ();
    logic [1:0]       req;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [1:0]       gnt;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;

    modport slave (
        input  req,
        input  in0,
        input  in1,
        input  y_ready,
        output gnt,
        output s,
        output y,
        output y_valid
    );

    modport master (
        output req,
        output in0,
        output in1,
        output y_ready,
        input  gnt,
        input  s,
        input  y,
        input  y_valid
    );
endinterface

// File: rtl/mux_share_arbiter.sv
// rtl/mux_share_arbiter.sv - round-robin owner of a shared 2:1 mux channel with bounded bursts
//
// Ports:
//   clk     system clock, all state on its rising edge
//   rst_n   asynchronous active-low reset
//   bus     mux_share_arbiter_if.slave: req/in0/in1/y_ready in, gnt/s/y/y_valid out
//
// Parameters:
//   WIDTH      data width of in0, in1 and y
//   MAX_BURST  beats one requester may move while the other waits (>= 1)
module mux_share_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_share_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    // Value the counter holds just before the beat that completes a burst.
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_nx;
    logic            s_q;
    logic            s_nx;
    logic            last_q;
    logic            last_nx;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_nx;

    logic [1:0]       gnt_w;
    logic             y_valid_w;
    logic [WIDTH-1:0] y_mux;
    logic             beat;
    logic             own_k;
    logic             own_req;
    logic             other_req;
    logic             do_enter;
    logic             enter_k;

    // Grant is decoded straight from the state register, so it is glitch-free.
    assign gnt_w     = {state_q == OWN1, state_q == OWN0};
    assign y_mux     = s_q ? bus.in1 : bus.in0;
    assign y_valid_w = gnt_w[s_q] & bus.req[s_q];
    assign beat      = y_valid_w & bus.y_ready;

    assign own_k     = (state_q == OWN1);
    assign own_req   = bus.req[own_k];
    assign other_req = bus.req[~own_k];

    assign bus.gnt     = gnt_w;
    assign bus.s       = s_q;
    assign bus.y       = y_mux;
    assign bus.y_valid = y_valid_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            s_q     <= s_nx;
            last_q  <= last_nx;
            cnt_q   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        s_nx     = s_q;
        last_nx  = last_q;
        cnt_nx   = cnt_q;
        do_enter = 1'b0;
        enter_k  = 1'b0;

        case (state_q)
            IDLE: begin
                // s is left alone while idle; it only moves on entering an owner state.
                if (bus.req != 2'b00) begin
                    do_enter = 1'b1;
                    enter_k  = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    // Release wins over burst completion; with req low there is no beat anyway.
                    if (other_req) begin
                        do_enter = 1'b1;
                        enter_k  = ~own_k;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else if (beat) begin
                    if (cnt_q == CNT_LAST) begin
                        if (other_req) begin
                            do_enter = 1'b1;
                            enter_k  = ~own_k;
                        end else begin
                            // Nobody is waiting: keep ownership and open a fresh burst.
                            cnt_nx = '0;
                        end
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        if (do_enter) begin
            state_nx = enter_k ? OWN1 : OWN0;
            s_nx     = enter_k;
            last_nx  = enter_k;
            cnt_nx   = '0;
        end
    end
endmodule
